// File: rtl/scratch_pad_bank_arbiter_pkg.sv
// scratch_pad_bank_arbiter_pkg
//   Shared definitions for the banked scratch-pad arbiter: access kinds,
//   statistics counter width, index-width and vector-slicing helpers.
//   Port and bank vectors are MSB-first: element i of an N-element vector
//   of W-bit words sits at bit offset (N-1-i)*W.
package scratch_pad_bank_arbiter_pkg;

    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_e;

    // Bits needed to index n items (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

    // Low bit offset of element idx in an MSB-first vector of n w-bit words.
    function automatic int unsigned slice_lo(input int unsigned idx,
                                             input int unsigned n,
                                             input int unsigned w);
        return (n - 1 - idx) * w;
    endfunction

endpackage

// File: rtl/scratch_pad_bank_arbiter_rr_arbiter.sv
// scratch_pad_bank_arbiter_rr_arbiter
//   Round-robin arbiter for one bank. The search starts one past the last
//   granted port; the pointer moves only when a grant is issued and resets
//   to PORTS-1 so port 0 wins first.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   i_req  request vector, bit p = port p
//   o_gnt  one-hot grant (combinational), bit p = port p
module scratch_pad_bank_arbiter_rr_arbiter
    import scratch_pad_bank_arbiter_pkg::*;
#(
    parameter int unsigned PORTS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] i_req,
    output logic [PORTS-1:0] o_gnt
);

    localparam int unsigned PW = idx_w(PORTS);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic          w_any;
    int unsigned   w_idx;

    always_comb begin
        o_gnt = '0;
        w_win = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            w_idx = (32'(r_ptr) + k) % PORTS;
            if (!w_any && i_req[w_idx]) begin
                w_any        = 1'b1;
                w_win        = PW'(w_idx);
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PW'(PORTS - 1);
        end else if (w_any) begin
            r_ptr <= w_win;
        end
    end

endmodule

// File: rtl/scratch_pad_bank_arbiter.sv
// scratch_pad_bank_arbiter
//   Schedules PORTS requesters onto BANKS single-ported scratch-pad RAMs.
//   Low address bits pick the bank; each bank arbitrates round-robin and
//   drives registered strobes. A per-bank tag pipeline routes bank_q back
//   to the requesting port, giving a fixed RD_LATENCY+2 read latency.
//   Optional build macro SCRATCH_PAD_ARB_STATS_EN adds stat_conflicts:
//   per-port saturating counts of cycles with full asserted.
// Ports (port/bank vectors MSB-first, element 0 in the top slice):
//   clk, rst     clock, synchronous active-high reset
//   rd_en/wr_en  per-port read/write request
//   d, addr      per-port write data and word address
//   stall        per-port: block new read grants
//   full         per-port: request present but not granted (combinational)
//   q, valid     per-port registered read return
//   bank_*       registered bank strobes, local address, write data
//   bank_q       bank read data, RD_LATENCY cycles after bank_rd_en
module scratch_pad_bank_arbiter
    import scratch_pad_bank_arbiter_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned BANKS      = 4,
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned RD_LATENCY = 2,
    localparam int unsigned BSEL_W    = idx_w(BANKS),
    localparam int unsigned BANK_AW   = ADDR_WIDTH - BSEL_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [0:PORTS-1]            rd_en,
    input  logic [0:PORTS-1]            wr_en,
    input  logic [PORTS*WIDTH-1:0]      d,
    input  logic [PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [0:PORTS-1]            stall,
    output logic [0:PORTS-1]            full,
    output logic [PORTS*WIDTH-1:0]      q,
    output logic [0:PORTS-1]            valid,
    output logic [0:BANKS-1]            bank_rd_en,
    output logic [0:BANKS-1]            bank_wr_en,
    output logic [BANKS*BANK_AW-1:0]    bank_addr,
    output logic [BANKS*WIDTH-1:0]      bank_d,
    input  logic [BANKS*WIDTH-1:0]      bank_q
`ifdef SCRATCH_PAD_ARB_STATS_EN
    ,
    output logic [PORTS*STAT_W-1:0]     stat_conflicts
`endif
);

    localparam int unsigned PW    = idx_w(PORTS);
    localparam int unsigned TAG_W = PW + 1;

    logic [WIDTH-1:0]   w_d      [PORTS];
    logic [BSEL_W-1:0]  w_bsel   [PORTS];
    logic [BANK_AW-1:0] w_baddr  [PORTS];
    logic [PORTS-1:0]   w_elig;
    logic [PORTS-1:0]   w_granted;
    logic [PORTS-1:0]   w_gnt_all [BANKS];
    logic               w_ret_live [BANKS];
    logic [PW-1:0]      w_ret_pid  [BANKS];
    logic [WIDTH-1:0]   w_bank_q   [BANKS];
    logic [WIDTH-1:0]   r_q        [PORTS];
    logic [PORTS-1:0]   r_valid;

    genvar gp, gb;

    for (gp = 0; gp < PORTS; gp++) begin : g_port
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr      = addr[slice_lo(gp, PORTS, ADDR_WIDTH) +: ADDR_WIDTH];
        assign w_d[gp]     = d[slice_lo(gp, PORTS, WIDTH) +: WIDTH];
        assign w_bsel[gp]  = w_addr[BSEL_W-1:0];
        assign w_baddr[gp] = w_addr[ADDR_WIDTH-1:BSEL_W];
        // Requests seen during reset are never eligible, so they show as full.
        assign w_elig[gp]  = !rst && (wr_en[gp] || (rd_en[gp] && !stall[gp]));
        assign full[gp]    = (rd_en[gp] || wr_en[gp]) && !w_granted[gp];
        assign q[slice_lo(gp, PORTS, WIDTH) +: WIDTH] = r_q[gp];
        assign valid[gp]   = r_valid[gp];
    end

    always_comb begin
        w_granted = '0;
        for (int unsigned b = 0; b < BANKS; b++) begin
            w_granted = w_granted | w_gnt_all[b];
        end
    end

    for (gb = 0; gb < BANKS; gb++) begin : g_bank
        logic [PORTS-1:0]   w_req;
        logic [PORTS-1:0]   w_gnt;
        acc_e               w_op;
        logic [BANK_AW-1:0] w_win_addr;
        logic [WIDTH-1:0]   w_win_d;
        logic [PW-1:0]      w_win_pid;
        logic               r_rd;
        logic               r_wr;
        logic [BANK_AW-1:0] r_addr;
        logic [WIDTH-1:0]   r_d;
        // Stage k holds {live, port_id} for the access strobed k cycles ago.
        logic [TAG_W-1:0]   r_tag [RD_LATENCY+1];

        always_comb begin
            w_req = '0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                w_req[p] = w_elig[p] && (w_bsel[p] == BSEL_W'(gb));
            end
        end

        scratch_pad_bank_arbiter_rr_arbiter #(
            .PORTS (PORTS)
        ) u_rr (
            .clk   (clk),
            .rst   (rst),
            .i_req (w_req),
            .o_gnt (w_gnt)
        );

        always_comb begin
            w_op       = ACC_IDLE;
            w_win_addr = '0;
            w_win_d    = '0;
            w_win_pid  = '0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (w_gnt[p]) begin
                    w_op       = wr_en[p] ? ACC_WRITE : ACC_READ;
                    w_win_addr = w_baddr[p];
                    w_win_d    = w_d[p];
                    w_win_pid  = PW'(p);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd   <= 1'b0;
                r_wr   <= 1'b0;
                r_addr <= '0;
                r_d    <= '0;
                for (int unsigned k = 0; k <= RD_LATENCY; k++) begin
                    r_tag[k] <= '0;
                end
            end else begin
                r_rd <= (w_op == ACC_READ);
                r_wr <= (w_op == ACC_WRITE);
                if (w_op != ACC_IDLE) begin
                    r_addr <= w_win_addr;
                    r_d    <= w_win_d;
                end
                r_tag[0] <= {(w_op == ACC_READ), w_win_pid};
                for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
                    r_tag[k] <= r_tag[k-1];
                end
            end
        end

        assign w_gnt_all[gb]  = w_gnt;
        assign w_ret_live[gb] = r_tag[RD_LATENCY][TAG_W-1];
        assign w_ret_pid[gb]  = r_tag[RD_LATENCY][PW-1:0];
        assign w_bank_q[gb]   = bank_q[slice_lo(gb, BANKS, WIDTH) +: WIDTH];
        assign bank_rd_en[gb] = r_rd;
        assign bank_wr_en[gb] = r_wr;
        assign bank_addr[slice_lo(gb, BANKS, BANK_AW) +: BANK_AW] = r_addr;
        assign bank_d[slice_lo(gb, BANKS, WIDTH) +: WIDTH]        = r_d;
    end

    // A port wins at most one bank per cycle and every read has the same
    // latency, so at most one live tag targets a given port in any cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                r_q[p] <= '0;
            end
        end else begin
            r_valid <= '0;
            for (int unsigned b = 0; b < BANKS; b++) begin
                if (w_ret_live[b]) begin
                    r_q[w_ret_pid[b]]     <= w_bank_q[b];
                    r_valid[w_ret_pid[b]] <= 1'b1;
                end
            end
        end
    end

`ifdef SCRATCH_PAD_ARB_STATS_EN
    for (gp = 0; gp < PORTS; gp++) begin : g_stat
        logic [STAT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (full[gp] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign stat_conflicts[slice_lo(gp, PORTS, STAT_W) +: STAT_W] = r_cnt;
    end
`endif

endmodule
